div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//  Multi-cycle controller for MIPS DIV/DIVU. It runs a radix-2 restoring divider
//  (one quotient bit per cycle) and holds the pipeline through the stall bus while
//  busy. Sits beside EX: EX raises div_start with rs/rt operands, forwards
//  stallreq to the stall controller, and writes div_result into HI/LO on div_ready.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH; counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk         in   1        system clock, rising edge
//  rst         in   1        asynchronous, active-high reset
//  div_start   in   1        divide requested by the instruction in EX (level, held while stalled)
//  div_signed  in   1        1 = DIV (signed), 0 = DIVU
//  div_annul   in   1        cancel: EX instruction flushed
//  opdata1     in   WIDTH    dividend (rs)
//  opdata2     in   WIDTH    divisor (rt)
//  div_result  out  2*WIDTH  {remainder -> HI, quotient -> LO}
//  div_ready   out  1        div_result valid
//  stallreq    out  1        request pipeline stall (Stop = 1)
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0, div_result=0, div_ready=0, stallreq=0.
//  States: IDLE, DIV_ZERO, DIV_ON, DIV_END. All transitions occur on the clk edge.
//  IDLE: start & ~annul & opdata2==0 -> DIV_ZERO. start & ~annul & opdata2!=0 -> DIV_ON.
//   - On the DIV_ON entry edge, latch |dividend| and |divisor|: two's-complement
//     abs when signed, raw when unsigned. Latch the sign flags. cnt=0.
//   - Working register = {WIDTH+1 partial remainder, WIDTH dividend/quotient}, cleared.
//  DIV_ON: each cycle, shift left 1 and trial-subtract divisor from the upper part.
//   - Non-negative difference: keep it and set the quotient LSB to 1. Else restore, LSB 0.
//   - cnt increments each cycle. On the edge where cnt==WIDTH-1 the last bit is
//     formed -> DIV_END.
//  DIV_ZERO: one cycle -> DIV_END. Result: quotient=all ones, remainder=opdata1 as
//   latched (fixed value, not a trap).
//  DIV_END: div_ready=1 and div_result is held stable.
//   - Signed: quotient negated when the dividend and divisor signs differ; remainder
//     takes the sign of the dividend.
//   - Returns to IDLE on the first cycle that div_start=0 or div_annul=1.
//     div_ready and div_result then clear to 0.
//  Latency: start sampled at edge T. DIV_ON covers cycles T+1..T+WIDTH.
//   - div_ready=1 from cycle T+WIDTH+1, i.e. 33 cycles after T for WIDTH=32.
//   - Divide by zero: ready at T+2.
//  stallreq (combinational): 1 when
//   - (IDLE & div_start & ~div_annul), or
//   - DIV_ON, or
//   - DIV_ZERO.
//   Otherwise 0, including in DIV_END, so the pipeline advances in that cycle.
//  div_annul in any state: next state IDLE, cnt=0, div_ready=0, div_result=0.
//   stallreq drops in the same cycle that annul is high, because annul masks the
//   IDLE term and the next state is IDLE. Annul has priority over start.
//  Edge case: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0
//   (wraps, no overflow flag).
//  Operands are sampled only on the IDLE->DIV_ON/DIV_ZERO edge. Later changes on
//   opdata1/opdata2 are ignored.
// TESTING
//  1. DIVU 100/7, start at T -> stallreq high T..T+32; at T+33 ready=1,
//     result={32'd2, 32'd14}, stallreq=0.
//  2. DIV -7/2 (0xFFFFFFF9/2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
//     DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
//  3. DIVU 0x12345678/0 -> ready at T+2, result={32'h12345678, 32'hFFFFFFFF}.
//  4. DIV 0x80000000/0xFFFFFFFF -> result={32'h0, 32'h80000000}.
//     DIVU 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
//  5. div_annul at the 10th DIV_ON cycle -> IDLE next edge, ready=0, stallreq=0.
//     New start at the following edge completes correctly 33 cycles later.
//  6. rst pulse mid-DIV_ON, asynchronous between edges -> outputs 0 immediately.
//     Back-to-back divides with start dropped for one cycle in DIV_END both produce
//     correct results.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle controller for MIPS DIV/DIVU.
// Runs a radix-2 restoring divider that forms one quotient bit per clock.
// While the divider is busy it holds the pipeline through stallreq.
//
// Ports:
//   clk        in   rising-edge system clock
//   rst        in   asynchronous active-high reset
//   div_start  in   divide requested by the EX instruction (level, held while stalled)
//   div_signed in   1 = DIV (signed), 0 = DIVU
//   div_annul  in   cancel: EX instruction flushed (has priority over div_start)
//   opdata1    in   dividend (rs)
//   opdata2    in   divisor (rt)
//   div_result out  {remainder -> HI, quotient -> LO}, registered
//   div_ready  out  div_result valid, registered
//   stallreq   out  combinational stall request to the stall controller
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic               div_annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] div_result,
  output logic               div_ready,
  output logic               stallreq
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_END  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  // {partial remainder (WIDTH+1), dividend shifting out / quotient shifting in (WIDTH)}
  logic [2*WIDTH:0] work;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH-1:0] dividend_raw;
  logic             dividend_neg;
  logic             divisor_neg;

  logic [2*WIDTH:0] shifted;
  logic [2*WIDTH:0] work_next;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             last_iter;

  // Two's-complement magnitude when the operand is treated as signed, raw otherwise.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      magnitude = -v;
    end else begin
      magnitude = v;
    end
  endfunction

  // One restoring-division step plus the signed fix-up of the final result.
  always_comb begin
    shifted   = work << 1;
    diff      = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor_abs};
    work_next = shifted;
    if (!diff[WIDTH+1]) begin
      work_next = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
    end else begin
      work_next = shifted;
    end
    q_mag = work_next[WIDTH-1:0];
    r_mag = work_next[2*WIDTH-1:WIDTH];
    // Sign flags are only ever set for DIV, so DIVU passes straight through.
    // 0x80000000 / -1 negates 0x80000000 back to itself: the MIPS wrap behaviour.
    if (dividend_neg ^ divisor_neg) begin
      q_fix = -q_mag;
    end else begin
      q_fix = q_mag;
    end
    if (dividend_neg) begin
      r_fix = -r_mag;
    end else begin
      r_fix = r_mag;
    end
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and stall request. Annul masks every stall term because
  // the flushed instruction must not hold the pipeline.
  always_comb begin
    next_state = state;
    stallreq   = 1'b0;
    if (div_annul) begin
      next_state = IDLE;
      stallreq   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            stallreq = 1'b1;
            if (opdata2 == {WIDTH{1'b0}}) begin
              next_state = DIV_ZERO;
            end else begin
              next_state = DIV_ON;
            end
          end else begin
            next_state = IDLE;
          end
        end
        DIV_ZERO: begin
          stallreq   = 1'b1;
          next_state = DIV_END;
        end
        DIV_ON: begin
          stallreq = 1'b1;
          if (last_iter) begin
            next_state = DIV_END;
          end else begin
            next_state = DIV_ON;
          end
        end
        DIV_END: begin
          // Stall released here so EX advances and writes HI/LO this cycle.
          if (div_start) begin
            next_state = DIV_END;
          end else begin
            next_state = IDLE;
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Datapath: operand capture, iteration, and the held result/ready registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= {CW{1'b0}};
      work         <= {(2*WIDTH+1){1'b0}};
      divisor_abs  <= {WIDTH{1'b0}};
      dividend_raw <= {WIDTH{1'b0}};
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      div_result   <= {(2*WIDTH){1'b0}};
      div_ready    <= 1'b0;
    end else if (div_annul) begin
      cnt        <= {CW{1'b0}};
      div_result <= {(2*WIDTH){1'b0}};
      div_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_result <= {(2*WIDTH){1'b0}};
          div_ready  <= 1'b0;
          if (div_start) begin
            // Operands are only sampled here; later changes on the bus are ignored.
            cnt          <= {CW{1'b0}};
            work         <= {{(WIDTH+1){1'b0}}, magnitude(opdata1, div_signed)};
            divisor_abs  <= magnitude(opdata2, div_signed);
            dividend_raw <= opdata1;
            dividend_neg <= div_signed & opdata1[WIDTH-1];
            divisor_neg  <= div_signed & opdata2[WIDTH-1];
          end else begin
            cnt <= {CW{1'b0}};
          end
        end
        DIV_ZERO: begin
          // Fixed architectural value, no trap and no sign fix-up.
          div_result <= {dividend_raw, {WIDTH{1'b1}}};
          div_ready  <= 1'b1;
        end
        DIV_ON: begin
          work <= work_next;
          cnt  <= cnt + {{(CW-1){1'b0}}, 1'b1};
          if (last_iter) begin
            div_result <= {r_fix, q_fix};
            div_ready  <= 1'b1;
          end else begin
            div_ready  <= 1'b0;
          end
        end
        DIV_END: begin
          if (!div_start) begin
            div_result <= {(2*WIDTH){1'b0}};
            div_ready  <= 1'b0;
          end else begin
            div_ready  <= 1'b1;
          end
        end
        default: begin
          div_result <= {(2*WIDTH){1'b0}};
          div_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer (WIDTH = 32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stallreq;

  int vectors;
  int miscompares;

  div_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_annul  (div_annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .div_result (div_result),
    .div_ready  (div_ready),
    .stallreq   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a divide request; call just after a falling edge (that cycle is T).
  task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    div_signed = sgn;
    opdata1    = a;
    opdata2    = b;
    div_start  = 1'b1;
  endtask

  // Count falling edges until div_ready, bounded by budget.
  task automatic wait_ready(input int budget, output int cycles);
    cycles = 0;
    while (div_ready !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Issue a divide at the next falling edge and return its result and latency.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat);
    @(negedge clk);
    start_div(sgn, a, b);
    wait_ready(40, lat);
    res = div_result;
  endtask

  // Drop div_start so DIV_END returns to IDLE on the next edge.
  task automatic end_div();
    div_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; div_start = 1'b0; div_signed = 1'b0; div_annul = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;
    #3;
    vectors++;
    if ({div_ready, stallreq, div_result} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset: ready=%b stall=%b result=%h required all zero", div_ready, stallreq, div_result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int bad;
    bad = 0;
    @(negedge clk);
    start_div(1'b0, 32'd100, 32'd7);
    #1;
    vectors++;
    if (stallreq !== 1'b1) begin
      miscompares++;
      $display("FAIL divu_stall_T: stallreq=%b required 1", stallreq);
    end
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (stallreq !== 1'b1 || div_ready !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL divu_busy_window: %0d bad cycles required 0", bad);
    end
    @(negedge clk);
    vectors++;
    if (div_ready !== 1'b1 || div_result !== {32'd2, 32'd14} || stallreq !== 1'b0) begin
      miscompares++;
      $display("FAIL divu_100_7: ready=%b stall=%b result=%h required 1 0 %h",
               div_ready, stallreq, div_result, {32'd2, 32'd14});
    end
    end_div();
    vectors++;
    if (div_ready !== 1'b0 || div_result !== 64'd0) begin
      miscompares++;
      $display("FAIL divu_release: ready=%b result=%h required 0 0", div_ready, div_result);
    end
  endtask

  task automatic test_signed();
    logic [63:0] res;
    int lat;
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat);
    vectors++;
    if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || lat != 33) begin
      miscompares++;
      $display("FAIL div_m7_2: result=%h lat=%0d required %h 33", res, lat, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    end_div();
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, res, lat);
    vectors++;
    if (res !== {32'd1, 32'hFFFF_FFFD}) begin
      miscompares++;
      $display("FAIL div_7_m2: result=%h required %h", res, {32'd1, 32'hFFFF_FFFD});
    end
    end_div();
    // -100 / -7 = 14 remainder -2
    do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, res, lat);
    vectors++;
    if (res !== {32'hFFFF_FFFE, 32'd14}) begin
      miscompares++;
      $display("FAIL div_m100_m7: result=%h required %h", res, {32'hFFFF_FFFE, 32'd14});
    end
    end_div();
  endtask

  task automatic test_div_zero();
    int lat;
    @(negedge clk);
    start_div(1'b0, 32'h1234_5678, 32'd0);
    @(negedge clk);
    vectors++;
    if (stallreq !== 1'b1 || div_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL divzero_busy: stall=%b ready=%b required 1 0", stallreq, div_ready);
    end
    // Operand changes after the sampling edge must be ignored.
    opdata1 = 32'hDEAD_BEEF;
    opdata2 = 32'd3;
    wait_ready(40, lat);
    vectors++;
    if (lat != 1 || div_result !== {32'h1234_5678, 32'hFFFF_FFFF} || stallreq !== 1'b0) begin
      miscompares++;
      $display("FAIL divzero_result: result=%h extra_lat=%0d stall=%b required %h 1 0",
               div_result, lat, stallreq, {32'h1234_5678, 32'hFFFF_FFFF});
    end
    end_div();
  endtask

  task automatic test_boundary();
    logic [63:0] res;
    int lat;
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    vectors++;
    if (res !== {32'h0, 32'h8000_0000}) begin
      miscompares++;
      $display("FAIL div_min_m1: result=%h required %h", res, {32'h0, 32'h8000_0000});
    end
    end_div();
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, res, lat);
    vectors++;
    if (res !== {32'h0, 32'hFFFF_FFFF}) begin
      miscompares++;
      $display("FAIL divu_max_1: result=%h required %h", res, {32'h0, 32'hFFFF_FFFF});
    end
    end_div();
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    vectors++;
    if (res !== {32'h8000_0000, 32'h0}) begin
      miscompares++;
      $display("FAIL divu_small_big: result=%h required %h", res, {32'h8000_0000, 32'h0});
    end
    end_div();
    do_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, res, lat);
    vectors++;
    if (res !== {32'd1, 32'd1}) begin
      miscompares++;
      $display("FAIL divu_max_maxm1: result=%h required %h", res, {32'd1, 32'd1});
    end
    end_div();
  endtask

  task automatic test_operand_latch();
    int lat;
    @(negedge clk);
    start_div(1'b0, 32'd1000, 32'd10);
    repeat (3) @(negedge clk);
    opdata1 = 32'd5;
    opdata2 = 32'd0;
    wait_ready(40, lat);
    vectors++;
    if (div_result !== {32'd0, 32'd100} || lat != 30) begin
      miscompares++;
      $display("FAIL latch_1000_10: result=%h rest_lat=%0d required %h 30", div_result, lat, {32'd0, 32'd100});
    end
    end_div();
  endtask

  task automatic test_annul();
    int lat;
    @(negedge clk);
    start_div(1'b0, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    div_annul = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (stallreq !== 1'b0 || div_ready !== 1'b0 || div_result !== 64'd0) begin
      miscompares++;
      $display("FAIL annul_on: stall=%b ready=%b result=%h required 0 0 0", stallreq, div_ready, div_result);
    end
    div_annul = 1'b0;
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    wait_ready(40, lat);
    vectors++;
    if (div_result !== {32'd1, 32'd333} || lat != 33) begin
      miscompares++;
      $display("FAIL annul_restart: result=%h lat=%0d required %h 33", div_result, lat, {32'd1, 32'd333});
    end
    // Annul while in DIV_END with start still held.
    div_annul = 1'b1;
    @(negedge clk);
    vectors++;
    if (div_ready !== 1'b0 || div_result !== 64'd0) begin
      miscompares++;
      $display("FAIL annul_end: ready=%b result=%h required 0 0", div_ready, div_result);
    end
    div_annul = 1'b0;
    end_div();
  endtask

  task automatic test_reset_async();
    logic [63:0] res;
    int lat;
    @(negedge clk);
    start_div(1'b0, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    div_start = 1'b0;
    #1;
    vectors++;
    if (stallreq !== 1'b0 || div_ready !== 1'b0 || div_result !== 64'd0) begin
      miscompares++;
      $display("FAIL rst_div_on: stall=%b ready=%b result=%h required 0 0 0", stallreq, div_ready, div_result);
    end
    @(negedge clk);
    rst = 1'b0;
    do_div(1'b0, 32'd50, 32'd8, res, lat);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (div_ready !== 1'b0 || div_result !== 64'd0) begin
      miscompares++;
      $display("FAIL rst_div_end: ready=%b result=%h required 0 0", div_ready, div_result);
    end
    div_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat;
    do_div(1'b0, 32'd50, 32'd8, res, lat);
    vectors++;
    if (res !== {32'd2, 32'd6} || lat != 33) begin
      miscompares++;
      $display("FAIL b2b_first: result=%h lat=%0d required %h 33", res, lat, {32'd2, 32'd6});
    end
    div_start = 1'b0;
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat);
    vectors++;
    if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || lat != 33) begin
      miscompares++;
      $display("FAIL b2b_second: result=%h lat=%0d required %h 33", res, lat, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    end_div();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_boundary();
    test_operand_latch();
    test_annul();
    test_reset_async();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1);
  end

endmodule
